// File: rtl/window_ctrl_3x3.sv
// Raster sequencer for the 3x3 filter front end: tracks pixel position and drives
// the window shift, line-buffer push/pop/clear strobes and window-complete flags.
module window_ctrl_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          shift_en,
    output logic          lb1_wr_en,
    output logic          lb1_rd_en,
    output logic          lb0_rd_en,
    output logic          lb_clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          win_valid,
    output logic          frame_done,
    output logic          sof_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } pos_t;

    state_t state;
    pos_t   npos;   // position the next accepted pixel will occupy
    pos_t   ppos;   // position of the pixel accepted this cycle

    logic accept;
    logic mid_sof;
    logic last_px;
    logic line_end;
    logic qualify;

    // Only a pending, unconsumed window holds off the source.
    assign in_ready = !(win_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel always lands at (0,0), whatever was expected next.
    assign ppos     = in_sof ? '0 : npos;

    assign shift_en  = accept && (in_sof || (state == ACTIVE));
    assign lb1_wr_en = shift_en;
    assign lb1_rd_en = shift_en && (ppos.r >= RW'(1));
    assign lb0_rd_en = shift_en && (ppos.r >= RW'(2));
    assign lb_clr    = accept && in_sof;

    assign mid_sof  = accept && in_sof && (state == ACTIVE) && (npos != '0);
    assign line_end = (ppos.c == CW'(IMG_WIDTH - 1));
    assign last_px  = line_end && (ppos.r == RW'(IMG_HEIGHT - 1));
    // Columns 0 and 1 still hold pixels from the previous line's tail.
    assign qualify  = (ppos.r >= RW'(2)) && (ppos.c >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            npos       <= '0;
            row        <= '0;
            col        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else if (shift_en) begin
            row        <= ppos.r;
            col        <= ppos.c;
            win_valid  <= qualify;
            frame_done <= last_px;
            sof_err    <= mid_sof;
            if (last_px) begin
                state <= IDLE;
                npos  <= '0;
            end else if (line_end) begin
                state  <= ACTIVE;
                npos.r <= ppos.r + 1'b1;
                npos.c <= '0;
            end else begin
                state  <= ACTIVE;
                npos.r <= ppos.r;
                npos.c <= ppos.c + 1'b1;
            end
        end else begin
            win_valid  <= win_valid && !out_ready;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end
    end

endmodule
